// File: rtl/bitclk_pkg.sv
// Shared types and constants for the NRZ bit-stream generator and its bit timer.
package bitclk_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int DEFAULT_CLK_LEN = 32;
    localparam int MIN_BIT_PERIOD  = 2;

    localparam logic [6:0] PRBS7_SEED   = 7'h7F;
    localparam int         PRBS7_TAP_HI = 6;
    localparam int         PRBS7_TAP_LO = 5;

    // x^7 + x^6 + 1 Fibonacci step; the serial output is bit 6 before the step.
    function automatic logic [6:0] prbs7_next(input logic [6:0] lfsr);
        return {lfsr[5:0], lfsr[PRBS7_TAP_HI] ^ lfsr[PRBS7_TAP_LO]};
    endfunction

endpackage

// File: rtl/bit_stream_gen_bit_timer.sv
// Bit timer: latches the clamped bit period, runs the per-bit tick counter and
// produces the registered mid-bit reference clock plus a bit_end pulse.
module bit_timer
    import bitclk_pkg::*;
#(
    parameter int CLK_LEN = DEFAULT_CLK_LEN
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               active_i,
    input  logic               next_active_i,
    input  logic [CLK_LEN-1:0] bit_period_i,
    output logic               bit_end_o,
    output logic               clk_ref_o
);

    localparam logic [CLK_LEN-1:0] MIN_PERIOD = CLK_LEN'(MIN_BIT_PERIOD);
    localparam logic [CLK_LEN-1:0] ZERO       = {CLK_LEN{1'b0}};
    localparam logic [CLK_LEN-1:0] ONE        = CLK_LEN'(1);

    logic [CLK_LEN-1:0] tick_q;
    logic [CLK_LEN-1:0] tick_d;
    logic [CLK_LEN-1:0] period_q;
    logic [CLK_LEN-1:0] period_d;
    logic               clk_ref_q;
    logic               clk_ref_d;
    logic               bit_end_s;

    function automatic logic [CLK_LEN-1:0] clamp_period(input logic [CLK_LEN-1:0] p);
        logic [CLK_LEN-1:0] r;
        if (p < MIN_PERIOD) begin
            r = MIN_PERIOD;
        end else begin
            r = p;
        end
        return r;
    endfunction

    assign bit_end_s = active_i && (tick_q == (period_q - ONE));
    assign bit_end_o = bit_end_s;
    assign clk_ref_o = clk_ref_q;

    // Tick/period next state; clk_ref is judged against the tick value of the next cycle.
    always_comb begin
        period_d = period_q;
        tick_d   = ZERO;
        if (start_i) begin
            period_d = clamp_period(bit_period_i);
            tick_d   = ZERO;
        end else if (active_i && !bit_end_s) begin
            tick_d = tick_q + ONE;
        end else begin
            tick_d = ZERO;
        end
        clk_ref_d = next_active_i && (tick_d >= (period_d >> 1));
    end

    // Timer state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tick_q    <= ZERO;
            period_q  <= MIN_PERIOD;
            clk_ref_q <= 1'b0;
        end else begin
            tick_q    <= tick_d;
            period_q  <= period_d;
            clk_ref_q <= clk_ref_d;
        end
    end

endmodule

// File: rtl/bit_stream_gen.sv
// NRZ bit-stream transmitter: serializes handshaked words MSB-first at a programmable bit period.
// Optional PRBS7 test source enabled by defining BIT_STREAM_GEN_PRBS_EN.
module bit_stream_gen
    import bitclk_pkg::*;
#(
    parameter int   CLK_LEN    = DEFAULT_CLK_LEN,
    parameter int   WORD_LEN   = 32,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic                clk_300M,
    input  logic                rst,
    input  logic                enable,
    input  logic [CLK_LEN-1:0]  bit_period,
    input  logic [WORD_LEN-1:0] data_in,
    input  logic                data_valid,
`ifdef BIT_STREAM_GEN_PRBS_EN
    input  logic                prbs_mode,
`endif
    output logic                data_ready,
    output logic                signal,
    output logic                clk_ref,
    output logic                bit_strobe,
    output logic                busy,
    output logic                underrun
);

    localparam int CNT_W = $clog2(WORD_LEN);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_LEN - 1);

    state_e              state_q;
    state_e              state_d;
    logic [WORD_LEN-1:0] shift_q;
    logic [WORD_LEN-1:0] shift_d;
    logic [CNT_W-1:0]    bit_cnt_q;
    logic [CNT_W-1:0]    bit_cnt_d;
    logic                signal_q;
    logic                signal_d;
    logic                bit_strobe_q;
    logic                bit_strobe_d;
    logic                busy_q;
    logic                busy_d;
    logic                underrun_q;
    logic                underrun_d;

    logic                start_s;
    logic                bit_end_s;
    logic                last_bit_s;
    logic                word_end_s;
    logic                ready_s;
    logic                xfer_s;
    logic                prbs_mode_s;
    logic                prbs_cur_s;
    logic                prbs_req_s;

`ifdef BIT_STREAM_GEN_PRBS_EN
    logic                prbs_q;
    logic                prbs_d;
    logic [6:0]          lfsr_q;
    logic [6:0]          lfsr_d;

    assign prbs_mode_s = prbs_mode;
    assign prbs_cur_s  = prbs_q;
`else
    assign prbs_mode_s = 1'b0;
    assign prbs_cur_s  = 1'b0;
`endif

    // A PRBS "word" is a single bit, so every PRBS bit end is also a word end.
    assign last_bit_s = (bit_cnt_q == CNT_ZERO);
    assign word_end_s = bit_end_s && (last_bit_s || prbs_cur_s);
    assign prbs_req_s = enable && prbs_mode_s;
    assign ready_s    = enable && !prbs_mode_s && ((state_q == IDLE) || word_end_s);
    assign xfer_s     = data_valid && ready_s;

    assign data_ready = ready_s;
    assign signal     = signal_q;
    assign bit_strobe = bit_strobe_q;
    assign busy       = busy_q;
    assign underrun   = underrun_q;

    bit_timer #(
        .CLK_LEN(CLK_LEN)
    ) u_bit_timer (
        .clk_i        (clk_300M),
        .rst_i        (rst),
        .start_i      (start_s),
        .active_i     (state_q == SHIFT),
        .next_active_i(state_d == SHIFT),
        .bit_period_i (bit_period),
        .bit_end_o    (bit_end_s),
        .clk_ref_o    (clk_ref)
    );

    // Next-state and output decode for the IDLE/SHIFT controller.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        signal_d     = IDLE_LEVEL;
        bit_strobe_d = 1'b0;
        busy_d       = 1'b0;
        underrun_d   = 1'b0;
        start_s      = 1'b0;
`ifdef BIT_STREAM_GEN_PRBS_EN
        prbs_d       = prbs_q;
        lfsr_d       = lfsr_q;
`endif
        case (state_q)
            IDLE: begin
                if (prbs_req_s) begin
                    state_d      = SHIFT;
                    start_s      = 1'b1;
                    busy_d       = 1'b1;
                    bit_strobe_d = 1'b1;
`ifdef BIT_STREAM_GEN_PRBS_EN
                    signal_d     = lfsr_q[PRBS7_TAP_HI];
                    lfsr_d       = prbs7_next(lfsr_q);
                    prbs_d       = 1'b1;
`endif
                end else if (xfer_s) begin
                    state_d      = SHIFT;
                    start_s      = 1'b1;
                    shift_d      = data_in;
                    bit_cnt_d    = CNT_LAST;
                    signal_d     = data_in[WORD_LEN-1];
                    bit_strobe_d = 1'b1;
                    busy_d       = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (!bit_end_s) begin
                    signal_d = signal_q;
                    busy_d   = 1'b1;
                end else if (prbs_req_s) begin
                    busy_d       = 1'b1;
                    bit_strobe_d = 1'b1;
`ifdef BIT_STREAM_GEN_PRBS_EN
                    signal_d     = lfsr_q[PRBS7_TAP_HI];
                    lfsr_d       = prbs7_next(lfsr_q);
                    prbs_d       = 1'b1;
`endif
                end else if (!last_bit_s && !prbs_cur_s) begin
                    shift_d      = {shift_q[WORD_LEN-2:0], 1'b0};
                    bit_cnt_d    = bit_cnt_q - CNT_ONE;
                    signal_d     = shift_q[WORD_LEN-2];
                    bit_strobe_d = 1'b1;
                    busy_d       = 1'b1;
                end else if (xfer_s) begin
                    start_s      = 1'b1;
                    shift_d      = data_in;
                    bit_cnt_d    = CNT_LAST;
                    signal_d     = data_in[WORD_LEN-1];
                    bit_strobe_d = 1'b1;
                    busy_d       = 1'b1;
`ifdef BIT_STREAM_GEN_PRBS_EN
                    prbs_d       = 1'b0;
`endif
                end else begin
                    state_d    = IDLE;
                    underrun_d = enable && !prbs_cur_s;
`ifdef BIT_STREAM_GEN_PRBS_EN
                    prbs_d     = 1'b0;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk_300M) begin
        if (rst) begin
            state_q      <= IDLE;
            shift_q      <= {WORD_LEN{1'b0}};
            bit_cnt_q    <= CNT_ZERO;
            signal_q     <= IDLE_LEVEL;
            bit_strobe_q <= 1'b0;
            busy_q       <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            signal_q     <= signal_d;
            bit_strobe_q <= bit_strobe_d;
            busy_q       <= busy_d;
            underrun_q   <= underrun_d;
        end
    end

`ifdef BIT_STREAM_GEN_PRBS_EN
    // PRBS mode flag and LFSR.
    always_ff @(posedge clk_300M) begin
        if (rst) begin
            prbs_q <= 1'b0;
            lfsr_q <= PRBS7_SEED;
        end else begin
            prbs_q <= prbs_d;
            lfsr_q <= lfsr_d;
        end
    end
`endif

endmodule
